// File: rtl/mmu_pkg.sv
// Shared types and parameter sanity helpers for the systolic GeMM engine.
package mmu_pkg;

   typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DRAIN} mmu_state_e;

   // The accumulator must hold at least one full-width signed product.
   function automatic bit widths_ok(int data_width, int acc_width, int rows, int cols);
      return (data_width >= 1) && (acc_width >= 2*data_width) && (rows >= 1) && (cols >= 1);
   endfunction

endpackage

// File: rtl/mmu_pe.sv
// One output-stationary MAC cell: multiplies the passing operands, keeps the sum, forwards a right / b down.
module mmu_pe #(
   parameter int DATA_WIDTH = 16,
   parameter int ACC_WIDTH  = 40
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  en,
   input  logic                  clr_acc,
   input  logic                  clr_pipe,
   input  logic [DATA_WIDTH-1:0] a_in,
   input  logic [DATA_WIDTH-1:0] b_in,
   output logic [DATA_WIDTH-1:0] a_out,
   output logic [DATA_WIDTH-1:0] b_out,
   output logic [ACC_WIDTH-1:0]  acc
);

   logic signed [2*DATA_WIDTH-1:0] prod;
   logic signed [ACC_WIDTH-1:0]    prod_ext;

   assign prod     = (2*DATA_WIDTH)'($signed(a_in)) * (2*DATA_WIDTH)'($signed(b_in));
   assign prod_ext = ACC_WIDTH'(prod);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         acc   <= '0;
         a_out <= '0;
         b_out <= '0;
      end else begin
         if (clr_acc)  acc <= '0;
         else if (en)  acc <= acc + prod_ext;
         if (clr_pipe) begin
            a_out <= '0;
            b_out <= '0;
         end else if (en) begin
            a_out <= a_in;
            b_out <= b_in;
         end
      end
   end

endmodule

// File: rtl/mmu_systolic_seq.sv
// ROWS x COLS output-stationary systolic GeMM: operand skew, tile sequencer and row-wise result drain.
module mmu_systolic_seq
   import mmu_pkg::*;
#(
   parameter int ROWS       = 4,
   parameter int COLS       = 4,
   parameter int DATA_WIDTH = 16,
   parameter int ACC_WIDTH  = 40,
   parameter int KLEN_W     = 16
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic                       cmd_acc,
   input  logic [KLEN_W-1:0]          cmd_k_len,
   input  logic                       abort_i,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [ROWS*DATA_WIDTH-1:0] in_data,
   input  logic [COLS*DATA_WIDTH-1:0] in_weight,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [$clog2(ROWS):0]      out_row,
   output logic [COLS*ACC_WIDTH-1:0]  out_data,
   output logic                       out_last,
   output logic                       busy
);

   localparam int RW         = $clog2(ROWS) + 1;
   localparam int FLUSH_LEN  = ROWS + COLS - 2;
   localparam int FLUSH_LAST = (FLUSH_LEN > 0) ? FLUSH_LEN - 1 : 0;
   localparam int FW         = $clog2(ROWS + COLS) + 1;

   if (!widths_ok(DATA_WIDTH, ACC_WIDTH, ROWS, COLS)) begin : g_bad_width
      $error("mmu_systolic_seq: need ROWS,COLS >= 1 and ACC_WIDTH >= 2*DATA_WIDTH");
   end

   mmu_state_e        state, state_nx;
   logic [KLEN_W-1:0] k_len_q, kcnt;
   logic [FW-1:0]     fcnt;
   logic [RW-1:0]     row;
   logic              adv, accept, stream, clr_acc, clr_pipe;

   logic [ROWS-1:0][COLS-1:0][DATA_WIDTH-1:0] a_w, b_w;
   logic [ROWS-1:0][COLS-1:0][ACC_WIDTH-1:0]  acc_w;
   logic [ROWS-1:0][DATA_WIDTH-1:0]           a_edge_unused;
   logic [COLS-1:0][DATA_WIDTH-1:0]           b_edge_unused;

   always_comb begin
      state_nx  = state;
      cmd_ready = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      adv       = 1'b0;
      accept    = 1'b0;
      unique case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               accept   = 1'b1;
               state_nx = (cmd_k_len == '0) ? DRAIN : STREAM;
            end
         end
         STREAM: begin
            in_ready = 1'b1;
            if (in_valid) begin
               adv = 1'b1;
               if (kcnt == k_len_q - KLEN_W'(1)) state_nx = (FLUSH_LEN == 0) ? DRAIN : FLUSH;
            end
         end
         FLUSH: begin
            adv = 1'b1;
            if (fcnt == FW'(FLUSH_LAST)) state_nx = DRAIN;
         end
         DRAIN: begin
            out_valid = 1'b1;
            if (out_ready && row == RW'(ROWS-1)) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
      // Abort overrides any handshake or command seen in the same cycle.
      if (abort_i) begin
         state_nx = IDLE;
         adv      = 1'b0;
         accept   = 1'b0;
      end
   end

   assign stream   = (state == STREAM);
   assign busy     = (state != IDLE);
   assign out_last = out_valid && (row == RW'(ROWS-1));
   assign out_row  = row;
   assign clr_pipe = abort_i | accept;
   assign clr_acc  = abort_i | (accept & ~cmd_acc);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state   <= IDLE;
         k_len_q <= '0;
         kcnt    <= '0;
         fcnt    <= '0;
         row     <= '0;
      end else begin
         state <= state_nx;
         if (abort_i || accept) begin
            kcnt <= '0;
            fcnt <= '0;
            row  <= '0;
            if (accept) k_len_q <= cmd_k_len;
         end else begin
            if (stream && in_valid) kcnt <= kcnt + KLEN_W'(1);
            if (state == FLUSH)     fcnt <= fcnt + FW'(1);
            if (out_valid && out_ready) row <= (row == RW'(ROWS-1)) ? '0 : row + RW'(1);
         end
      end
   end

   // Lane r of A is delayed r advances; lane 0 feeds PE(0,0) directly.
   for (genvar r = 0; r < ROWS; r++) begin : g_askew
      logic [DATA_WIDTH-1:0] lane;
      assign lane = stream ? in_data[r*DATA_WIDTH +: DATA_WIDTH] : '0;
      if (r == 0) begin : g_dir
         assign a_w[0][0] = lane;
      end else begin : g_dly
         logic [r-1:0][DATA_WIDTH-1:0] sk;
         always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i)         sk <= '0;
            else if (clr_pipe) sk <= '0;
            else if (adv) begin
               sk[0] <= lane;
               for (int i = 1; i < r; i++) sk[i] <= sk[i-1];
            end
         end
         assign a_w[r][0] = sk[r-1];
      end
   end

   for (genvar c = 0; c < COLS; c++) begin : g_bskew
      logic [DATA_WIDTH-1:0] lane;
      assign lane = stream ? in_weight[c*DATA_WIDTH +: DATA_WIDTH] : '0;
      if (c == 0) begin : g_dir
         assign b_w[0][0] = lane;
      end else begin : g_dly
         logic [c-1:0][DATA_WIDTH-1:0] sk;
         always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i)         sk <= '0;
            else if (clr_pipe) sk <= '0;
            else if (adv) begin
               sk[0] <= lane;
               for (int i = 1; i < c; i++) sk[i] <= sk[i-1];
            end
         end
         assign b_w[0][c] = sk[c-1];
      end
   end

   for (genvar r = 0; r < ROWS; r++) begin : g_row
      for (genvar c = 0; c < COLS; c++) begin : g_col
         logic [DATA_WIDTH-1:0] a_nx, b_nx;
         mmu_pe #(.DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_pe (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .en      (adv),
            .clr_acc (clr_acc),
            .clr_pipe(clr_pipe),
            .a_in    (a_w[r][c]),
            .b_in    (b_w[r][c]),
            .a_out   (a_nx),
            .b_out   (b_nx),
            .acc     (acc_w[r][c])
         );
         if (c == COLS-1) begin : g_ae
            assign a_edge_unused[r] = a_nx;
         end else begin : g_af
            assign a_w[r][c+1] = a_nx;
         end
         if (r == ROWS-1) begin : g_be
            assign b_edge_unused[c] = b_nx;
         end else begin : g_bf
            assign b_w[r+1][c] = b_nx;
         end
      end
   end

   always_comb begin
      out_data = '0;
      if (out_valid) begin
         for (int r = 0; r < ROWS; r++) begin
            if (row == RW'(r)) begin
               for (int c = 0; c < COLS; c++) out_data[c*ACC_WIDTH +: ACC_WIDTH] = acc_w[r][c];
            end
         end
      end
   end

endmodule

// File: tb/tb_mmu_systolic_seq.sv
// Scoreboarded bench for mmu_systolic_seq: per-scenario tasks, expected rows queued at command time.
module tb_mmu_systolic_seq;

   localparam int ROWS = 4;
   localparam int COLS = 4;
   localparam int DW   = 16;
   localparam int AW   = 32;
   localparam int KW   = 16;
   localparam int RW   = $clog2(ROWS) + 1;

   logic                 clk_i = 1'b0;
   logic                 rst_i = 1'b1;
   logic                 cmd_valid = 1'b0;
   logic                 cmd_ready;
   logic                 cmd_acc = 1'b0;
   logic [KW-1:0]        cmd_k_len = '0;
   logic                 abort_i = 1'b0;
   logic                 in_valid = 1'b0;
   logic                 in_ready;
   logic [ROWS*DW-1:0]   in_data = '0;
   logic [COLS*DW-1:0]   in_weight = '0;
   logic                 out_valid;
   logic                 out_ready = 1'b0;
   logic [RW-1:0]        out_row;
   logic [COLS*AW-1:0]   out_data;
   logic                 out_last;
   logic                 busy;

   always #5 clk_i = ~clk_i;

   mmu_systolic_seq #(.ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .KLEN_W(KW)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_acc(cmd_acc),
      .cmd_k_len(cmd_k_len), .abort_i(abort_i), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_weight(in_weight), .out_valid(out_valid), .out_ready(out_ready),
      .out_row(out_row), .out_data(out_data), .out_last(out_last), .busy(busy)
   );

   typedef struct {
      logic [RW-1:0]      row;
      logic [COLS*AW-1:0] data;
      logic               last;
   } exp_t;

   int checks = 0;
   int passed = 0;
   int busy_cnt = 0;
   exp_t sb[$];
   exp_t e_mon;
   logic [DW-1:0] opa [16][ROWS];
   logic [DW-1:0] opb [16][COLS];
   logic [AW-1:0] acc_m [ROWS][COLS];

   always @(negedge clk_i) if (busy) busy_cnt++;

   always @(negedge clk_i) begin
      if (!rst_i && out_valid && out_ready) begin
         checks++;
         if (sb.size() == 0) begin
            $display("FAIL sb_unexpected: got row %0d data %h, required no output", out_row, out_data);
         end else begin
            passed++;
            e_mon = sb.pop_front();
            checks++;
            if (out_row !== e_mon.row) $display("FAIL sb_row: got %0d, required %0d", out_row, e_mon.row);
            else passed++;
            checks++;
            if (out_data !== e_mon.data) $display("FAIL sb_data row %0d: got %h, required %h", e_mon.row, out_data, e_mon.data);
            else passed++;
            checks++;
            if (out_last !== e_mon.last) $display("FAIL sb_last row %0d: got %b, required %b", e_mon.row, out_last, e_mon.last);
            else passed++;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   function automatic logic [ROWS*DW-1:0] pack_a(int k);
      logic [ROWS*DW-1:0] v;
      for (int r = 0; r < ROWS; r++) v[r*DW +: DW] = opa[k][r];
      return v;
   endfunction

   function automatic logic [COLS*DW-1:0] pack_b(int k);
      logic [COLS*DW-1:0] v;
      for (int c = 0; c < COLS; c++) v[c*DW +: DW] = opb[k][c];
      return v;
   endfunction

   task automatic fill_rand(int k);
      for (int i = 0; i < k; i++) begin
         for (int r = 0; r < ROWS; r++) opa[i][r] = DW'($urandom);
         for (int c = 0; c < COLS; c++) opb[i][c] = DW'($urandom);
      end
   endtask

   task automatic model_clear();
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) acc_m[r][c] = '0;
   endtask

   // Updates the golden accumulators, queues the expected rows, then issues the command.
   task automatic send_cmd(logic acc, int k);
      exp_t e;
      longint p;
      if (!acc) model_clear();
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            for (int i = 0; i < k; i++) begin
               p = longint'($signed(opa[i][r])) * longint'($signed(opb[i][c]));
               acc_m[r][c] = acc_m[r][c] + AW'(p);
            end
      for (int r = 0; r < ROWS; r++) begin
         e.row = RW'(r);
         for (int c = 0; c < COLS; c++) e.data[c*AW +: AW] = acc_m[r][c];
         e.last = (r == ROWS-1);
         sb.push_back(e);
      end
      cmd_valid = 1'b1; cmd_acc = acc; cmd_k_len = KW'(k);
      @(posedge clk_i); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic send_beats(int k, int pct, output bit ok);
      int i = 0;
      int cyc = 0;
      bit hs;
      while (i < k && cyc < k*20 + 50) begin
         in_data = pack_a(i); in_weight = pack_b(i);
         in_valid = (pct >= 100) || ($urandom_range(99) < pct);
         @(negedge clk_i); hs = in_valid && in_ready;
         @(posedge clk_i); #1;
         if (hs) i++;
         cyc++;
      end
      in_valid = 1'b0;
      ok = (i == k);
   endtask

   task automatic wait_idle(int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk_i);
         if (!busy) begin ok = 1'b1; break; end
      end
      @(posedge clk_i); #1;
   endtask

   task automatic test_reset();
      @(negedge clk_i);
      checks++;
      if ({cmd_ready, in_ready, out_valid, out_last, busy} !== 5'b10000)
         $display("FAIL reset_ctrl: got rdy/in/ov/last/busy=%b, required 10000", {cmd_ready, in_ready, out_valid, out_last, busy});
      else passed++;
      checks++;
      if (out_row !== '0 || out_data !== '0) $display("FAIL reset_out: got row %0d data %h, required 0/0", out_row, out_data);
      else passed++;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      @(posedge clk_i); #1;
   endtask

   task automatic test_identity();
      bit ok1, ok2;
      for (int k = 0; k < 4; k++) begin
         for (int r = 0; r < ROWS; r++) opa[k][r] = (r == k) ? DW'(1) : DW'(0);
         for (int c = 0; c < COLS; c++) opb[k][c] = DW'(4*k + c + 1);
      end
      out_ready = 1'b1;
      busy_cnt = 0;
      send_cmd(1'b0, 4);
      send_beats(4, 100, ok1);
      wait_idle(100, ok2);
      checks++;
      if (!(ok1 && ok2)) $display("FAIL identity_timeout: got beats_ok=%b idle_ok=%b, required 1/1", ok1, ok2);
      else passed++;
      checks++;
      if (busy_cnt !== 14) $display("FAIL identity_busy: got %0d busy cycles, required 14", busy_cnt);
      else passed++;
   endtask

   task automatic test_bubbles();
      bit ok1, ok2;
      fill_rand(8);
      out_ready = 1'b1;
      send_cmd(1'b0, 8);
      send_beats(8, 50, ok1);
      wait_idle(100, ok2);
      checks++;
      if (!(ok1 && ok2)) $display("FAIL bubbles_timeout: got beats_ok=%b idle_ok=%b, required 1/1", ok1, ok2);
      else passed++;
   endtask

   task automatic test_backpressure();
      bit ok1, ok2, got;
      logic [COLS*AW-1:0] held;
      fill_rand(4);
      out_ready = 1'b0;
      send_cmd(1'b0, 4);
      send_beats(4, 100, ok1);
      for (int r = 0; r < ROWS; r++) begin
         got = 1'b0;
         for (int i = 0; i < 50; i++) begin
            @(negedge clk_i);
            if (out_valid) begin got = 1'b1; break; end
         end
         checks++;
         if (!got) $display("FAIL bp_valid row %0d: got no out_valid, required valid", r);
         else passed++;
         if (r == 1) begin
            held = out_data;
            for (int j = 0; j < 5; j++) begin
               @(negedge clk_i);
               checks++;
               if (out_valid !== 1'b1 || out_row !== RW'(1) || out_data !== held)
                  $display("FAIL bp_hold cycle %0d: got v=%b row=%0d data=%h, required v=1 row=1 data=%h", j, out_valid, out_row, out_data, held);
               else passed++;
            end
         end
         @(posedge clk_i); #1; out_ready = 1'b1;
         @(posedge clk_i); #1; out_ready = 1'b0;
      end
      wait_idle(20, ok2);
      checks++;
      if (!(ok1 && ok2)) $display("FAIL bp_timeout: got beats_ok=%b idle_ok=%b, required 1/1", ok1, ok2);
      else passed++;
   endtask

   task automatic test_accumulate();
      bit ok1, ok2, ok3, ok4, ok5;
      fill_rand(4);
      out_ready = 1'b1;
      send_cmd(1'b0, 4);
      send_beats(4, 100, ok1);
      wait_idle(100, ok2);
      send_cmd(1'b1, 4);
      send_beats(4, 100, ok3);
      wait_idle(100, ok4);
      send_cmd(1'b1, 0);
      wait_idle(20, ok5);
      checks++;
      if (!(ok1 && ok2 && ok3 && ok4 && ok5)) $display("FAIL acc_timeout: got %b%b%b%b%b, required 11111", ok1, ok2, ok3, ok4, ok5);
      else passed++;
   endtask

   task automatic test_wrap();
      bit ok1, ok2, got;
      logic [COLS*AW-1:0] want;
      want = {COLS{32'hC000_0000}};
      for (int i = 0; i < 3; i++) begin
         for (int r = 0; r < ROWS; r++) opa[i][r] = 16'h8000;
         for (int c = 0; c < COLS; c++) opb[i][c] = 16'h8000;
      end
      out_ready = 1'b0;
      send_cmd(1'b0, 3);
      send_beats(3, 100, ok1);
      got = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk_i);
         if (out_valid) begin got = 1'b1; break; end
      end
      checks++;
      if (!got || out_data !== want) $display("FAIL wrap_value: got valid=%b data %h, required %h", got, out_data, want);
      else passed++;
      @(posedge clk_i); #1; out_ready = 1'b1;
      wait_idle(20, ok2);
      checks++;
      if (!(ok1 && ok2)) $display("FAIL wrap_timeout: got beats_ok=%b idle_ok=%b, required 1/1", ok1, ok2);
      else passed++;
   endtask

   task automatic test_abort_reset();
      bit ok1, ok2, ok3, ok4, ok5;
      fill_rand(4);
      out_ready = 1'b1;
      send_cmd(1'b0, 4);
      send_beats(4, 100, ok1);
      abort_i = 1'b1;
      @(posedge clk_i); #1;
      abort_i = 1'b0;
      sb.delete();
      model_clear();
      @(negedge clk_i);
      checks++;
      if ({cmd_ready, in_ready, out_valid, busy} !== 4'b1000)
         $display("FAIL abort_state: got rdy/in/ov/busy=%b, required 1000", {cmd_ready, in_ready, out_valid, busy});
      else passed++;
      @(posedge clk_i); #1;
      // A zero-depth accumulate tile exposes whether abort cleared the array.
      send_cmd(1'b1, 0);
      wait_idle(20, ok2);
      fill_rand(4);
      send_cmd(1'b1, 4);
      send_beats(2, 100, ok3);
      rst_i = 1'b1;
      sb.delete();
      model_clear();
      @(negedge clk_i);
      checks++;
      if ({cmd_ready, in_ready, out_valid, out_last, busy} !== 5'b10000 || out_row !== '0 || out_data !== '0)
         $display("FAIL midreset_out: got ctrl=%b row=%0d data=%h, required 10000/0/0", {cmd_ready, in_ready, out_valid, out_last, busy}, out_row, out_data);
      else passed++;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      @(posedge clk_i); #1;
      fill_rand(4);
      send_cmd(1'b1, 4);
      send_beats(4, 100, ok4);
      wait_idle(100, ok5);
      checks++;
      if (!(ok1 && ok2 && ok3 && ok4 && ok5)) $display("FAIL abort_timeout: got %b%b%b%b%b, required 11111", ok1, ok2, ok3, ok4, ok5);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_identity();
      test_bubbles();
      test_backpressure();
      test_accumulate();
      test_wrap();
      test_abort_reset();
      repeat (3) @(posedge clk_i);
      checks++;
      if (sb.size() != 0) $display("FAIL sb_leftover: got %0d rows still expected, required 0", sb.size());
      else passed++;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
